// File: rtl/dct_pkg.sv
// Shared types for the 8x8 DCT transpose buffer: coefficient, row/column vector and index.
package dct_pkg;

  localparam int unsigned DCT_N     = 8;
  localparam int unsigned DCT_W     = 16;
  localparam int unsigned DCT_IDX_W = $clog2(DCT_N);

  typedef logic signed [DCT_W-1:0]     dct_coef_t;
  typedef dct_coef_t                   dct_vec_t [DCT_N-1:0];
  typedef logic        [DCT_IDX_W-1:0] dct_idx_t;

endpackage

// File: rtl/dct_tb_bank.sv
// One N x N coefficient bank: whole-row write port, whole-column combinational read.
module dct_tb_bank
  import dct_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  dct_idx_t wr_row,
  input  dct_vec_t wr_vec,
  input  dct_idx_t rd_col,
  output dct_vec_t rd_vec
);

  dct_coef_t mem_q [DCT_N][DCT_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DCT_N; r++) begin
        for (int c = 0; c < DCT_N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < DCT_N; c++) begin
        mem_q[wr_row][c] <= wr_vec[c];
      end
    end
  end

  // The transpose happens here: element r of the output is row r at the selected column.
  always_comb begin
    for (int r = 0; r < DCT_N; r++) begin
      rd_vec[r] = mem_q[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong row-in / column-out transpose buffer between the two 1-D DCT passes.
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  logic     in_sob,
  input  dct_vec_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output dct_vec_t out_data,
  output logic     out_last,
  output logic     sob_err
);

  localparam dct_idx_t LastIdx = dct_idx_t'(DCT_N - 1);

  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  dct_idx_t   row_cnt_q, row_cnt_d;
  dct_idx_t   col_cnt_q, col_cnt_d;
  logic [1:0] full_q, full_d;
  logic       sob_err_q, sob_err_d;

  logic       wr_fire, resync, blk_done;
  logic       rd_fire, col_done;
  dct_idx_t   wr_row;
  dct_vec_t   bank_rd [2];

  assign in_ready  = ~full_q[wr_sel_q];
  assign wr_fire   = in_valid & in_ready;
  // An accepted start-of-block mid-block abandons the partial rows and restarts at row 0.
  assign resync    = wr_fire & in_sob & (row_cnt_q != '0);
  assign wr_row    = resync ? '0 : row_cnt_q;
  assign blk_done  = wr_fire & ~resync & (row_cnt_q == LastIdx);

  assign out_valid = full_q[rd_sel_q];
  assign rd_fire   = out_valid & out_ready;
  assign col_done  = rd_fire & (col_cnt_q == LastIdx);
  assign out_last  = out_valid & (col_cnt_q == LastIdx);
  assign sob_err   = sob_err_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tb_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_fire & (wr_sel_q == 1'(b))),
      .wr_row (wr_row),
      .wr_vec (in_data),
      .rd_col (col_cnt_q),
      .rd_vec (bank_rd[b])
    );
  end

  always_comb begin
    out_data = rd_sel_q ? bank_rd[1] : bank_rd[0];
  end

  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    wr_sel_d  = wr_sel_q ^ blk_done;
    rd_sel_d  = rd_sel_q ^ col_done;
    sob_err_d = resync;
    full_d    = full_q;

    if (wr_fire) begin
      if (resync) begin
        row_cnt_d = dct_idx_t'(1);
      end else if (blk_done) begin
        row_cnt_d = '0;
      end else begin
        row_cnt_d = row_cnt_q + dct_idx_t'(1);
      end
    end

    if (rd_fire) begin
      col_cnt_d = col_done ? '0 : col_cnt_q + dct_idx_t'(1);
    end

    // Write can only target an empty bank and read only a full one, so these never collide.
    if (col_done) full_d[rd_sel_q] = 1'b0;
    if (blk_done) full_d[wr_sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      full_q    <= '0;
      sob_err_q <= 1'b0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      full_q    <= full_d;
      sob_err_q <= sob_err_d;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomised bench for dct_transpose_buf against a block-FIFO model of the transpose.
module tb_dct_transpose_buf;
  import dct_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid, in_ready, in_sob;
  dct_vec_t in_data;
  logic     out_valid, out_ready, out_last, sob_err;
  dct_vec_t out_data;

  dct_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sob    (in_sob),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sob_err   (sob_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_sob = 0;

  // Model: completed blocks as a flat row-major coefficient queue (64 per block),
  // the partially written block, and the column position within the head block.
  int mq[$];
  int cur[64];
  int m_rows = 0;
  int m_col  = 0;
  bit m_acc  = 1'b0;
  bit e_sob  = 1'b0;

  // Source rows waiting to be offered (8 coefficients per row).
  int src_q[$];
  bit src_sob[$];
  int valid_pct = 100;
  int ready_pct = 100;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_row(input bit sob, input int v [8]);
    for (int c = 0; c < 8; c++) src_q.push_back(v[c]);
    src_sob.push_back(sob);
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (out_valid !== 1'b1 && cycles < budget);
    if (out_valid !== 1'b1) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((src_sob.size() != 0 || mq.size() != 0 || m_rows != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", 0, 1);
  endtask

  // Model update on every active edge, from the bench's own inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_rows = 0;
        m_col  = 0;
        m_acc  = 1'b0;
        e_sob  = 1'b0;
      end else begin
        bit rdy, vld;
        rdy   = mq.size() < 128;
        vld   = mq.size() >= 64;
        m_acc = in_valid && rdy;
        e_sob = 1'b0;
        if (vld && out_ready) begin
          if (m_col == 7) begin
            repeat (64) void'(mq.pop_front());
            m_col = 0;
          end else begin
            m_col++;
          end
        end
        if (m_acc) begin
          if (in_sob && m_rows != 0) begin
            m_rows = 0;
            e_sob  = 1'b1;
          end
          for (int c = 0; c < 8; c++) cur[m_rows*8 + c] = int'(in_data[c]);
          m_rows++;
          if (m_rows == 8) begin
            for (int k = 0; k < 64; k++) mq.push_back(cur[k]);
            m_rows = 0;
          end
        end
      end
    end
  end

  // Input driver: offers queued rows, retires a row once the model saw it accepted.
  initial begin
    in_valid  = 1'b0;
    in_sob    = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) in_data[c] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        repeat (8) void'(src_q.pop_front());
        void'(src_sob.pop_front());
      end
      if (src_sob.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        in_sob   = src_sob[0];
        for (int c = 0; c < 8; c++) in_data[c] = 16'(src_q[c]);
      end else begin
        in_valid = 1'b0;
        in_sob   = 1'($urandom_range(1));
        for (int c = 0; c < 8; c++) in_data[c] = 16'($urandom);
      end
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        bit ev;
        ev = mq.size() >= 64;
        chk("in_ready", in_ready, 32'(mq.size() < 128));
        chk("out_valid", out_valid, 32'(ev));
        chk("out_last", out_last, 32'(ev && m_col == 7));
        chk("sob_err", sob_err, 32'(e_sob));
        if (ev) begin
          for (int i = 0; i < 8; i++) chk("out_data", out_data[i], mq[i*8 + m_col]);
        end
      end
      if (sob_err === 1'b1) n_sob++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int row [8];
    int cyc;
    int s0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sob_err", sob_err, 0);
    for (int i = 0; i < 8; i++) chk("rst_out_data", out_data[i], 0);
    rst = 1'b0;
    @(negedge clk);

    // Single block, known pattern and latency.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[c] = 16*r + c;
      push_row(r == 0, row);
    end
    wait_valid(50, cyc);
    chk("first_col_latency", cyc, 9);
    chk("first_col_last", out_last, 0);
    for (int r = 0; r < 8; r++) chk("first_col_data", out_data[r], 16*r);
    wait_idle(200);

    // Back-to-back blocks with no gaps.
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[c] = 256*(b + 1) + 16*r + c;
        push_row(r == 0, row);
      end
    end
    wait_idle(200);

    // Backpressure: three blocks offered, two fit.
    ready_pct = 0;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[c] = -1000*(b + 1) - 8*r - c;
        push_row(r == 0, row);
      end
    end
    repeat (40) @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_col0_row7", out_data[7], -1056);
    ready_pct = 100;
    wait_idle(300);

    // Signed extremes in a checkerboard.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[c] = ((r + c) % 2 == 1) ? 32767 : -32768;
      push_row(r == 0, row);
    end
    wait_valid(50, cyc);
    chk("extreme_r0", out_data[0], -32768);
    chk("extreme_r1", out_data[1], 32767);
    wait_idle(200);

    // Early start-of-block after three rows.
    s0 = n_sob;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) row[c] = 7777;
      push_row(r == 0, row);
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[c] = 100*r - c;
      push_row(r == 0, row);
    end
    wait_idle(200);
    chk("sob_err_pulses", n_sob - s0, 1);

    // Reset after a full block plus four rows.
    ready_pct = 0;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 8; c++) row[c] = 31*r + c + 5;
      push_row(r % 8 == 0, row);
    end
    cyc = 0;
    while (src_sob.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) chk("mid_rst_out_data", out_data[i], 0);
    rst = 1'b0;
    ready_pct = 100;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[c] = $urandom_range(65535) - 32768;
      push_row(r == 0, row);
    end
    wait_idle(200);

    // Random traffic with random handshakes and occasional abandoned partial blocks.
    for (int b = 0; b < 12; b++) begin
      valid_pct = $urandom_range(100, 40);
      ready_pct = $urandom_range(100, 40);
      if ($urandom_range(3) == 0) begin
        int k;
        k = $urandom_range(7, 1);
        for (int r = 0; r < k; r++) begin
          for (int c = 0; c < 8; c++) row[c] = $urandom_range(65535) - 32768;
          push_row(r == 0, row);
        end
      end
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) row[c] = $urandom_range(65535) - 32768;
        push_row(r == 0, row);
      end
    end
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Row/column transpose buffer between the row-pass 1-D DCT math stage (8 signed 16-bit coefficients per cycle) and the column-pass 1-D DCT.
- Accepts eight rows of one 8x8 block and then emits the same block as eight columns.
- Ping-pong double-banked, so one block can be written while the previous block is read.
- Valid/ready handshakes on both sides.

Parameters:
W, 16, coefficient width (signed two's complement) on input and output.
N, 8, block dimension. Fixed at 8; other values are not supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  row present on in_data
in_ready  out  1  buffer can accept a row this cycle
in_sob  in  1  start of block; qualifies the row on in_data as row 0
in_data  in  N x W  row coefficients; in_data[i] = column i, signed
out_valid  out  1  column present on out_data
out_ready  in  1  downstream accepts column
out_data  out  N x W  column coefficients; out_data[i] = row i of the current column
out_last  out  1  high with column N-1 of a block
sob_err  out  1  one-cycle pulse: partial block discarded by an early in_sob

Behaviour:
- Reset (clk edge with rst=1) sets:
  - wr_sel=0, rd_sel=0, row counter=0, column counter=0, full[1:0]=0, all bank storage=0.
  - Resulting outputs: out_valid=0, out_last=0, out_data=0, sob_err=0, in_ready=1.
- Reset mid-block discards everything, including a full bank not yet read.
- Write side:
  - A row is accepted when in_valid && in_ready. It is stored into bank[wr_sel] at row[row_cnt], and row_cnt increments.
  - When row N-1 is accepted: set full[wr_sel], toggle wr_sel, row_cnt returns to 0.
  - in_ready = ~full[wr_sel] (combinational from registers).
- Re-sync:
  - If an accepted row has in_sob=1 while row_cnt != 0, the partial rows are abandoned and sob_err pulses the next cycle.
  - That row is written as row 0, and row_cnt becomes 1.
  - in_sob with row_cnt==0 is a normal start. in_sob is ignored when the row is not accepted.
- Read side:
  - out_valid = full[rd_sel].
  - out_data[i] = bank[rd_sel][row i][col_cnt].
  - out_last = out_valid && (col_cnt == N-1).
  - On out_valid && out_ready: col_cnt increments. At N-1 it wraps to 0, full[rd_sel] clears, and rd_sel toggles.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Latency: the first column appears (out_valid=1) on the cycle after row N-1 is accepted, provided the read side is idle.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle both take effect. Set and clear act on different banks and never conflict.
  - Both banks full: in_ready=0. Writes resume on the cycle after the read of column N-1 completes (full flag cleared).
- Throughput: with out_ready held high, the block sustains 1 row in and 1 column out per cycle with no bubbles (8 cycles per block each side).
- No arithmetic: coefficients pass bit-exact (W bits, sign preserved).

Decomposition:
- Package dct_pkg:
  - localparam DCT_N = 8.
  - typedef logic signed [15:0] dct_coef_t.
  - typedef dct_coef_t dct_vec_t [DCT_N-1:0].
- Sub-module dct_tb_bank: one N x N x W storage bank with
  - row write port (we, row index, vector);
  - column read mux (column index -> vector);
  - synchronous clear on rst.
- dct_transpose_buf instantiates two dct_tb_bank and holds the counters, full flags and handshake logic.

Test Plan:
1. Single block: rows r=0..7 with in_data[c] = 16*r + c, out_ready=1 → columns c=0..7 with out_data[r] = 16*r + c; out_valid first on the cycle after row 7 is accepted; out_last only with c=7.
2. Back-to-back blocks, out_ready=1, in_valid held high: in_ready never drops; block 2 columns follow block 1 with no gap; values are not mixed between banks.
3. Backpressure: out_ready=0 while three blocks are offered → two blocks accepted, then in_ready=0 before row 0 of block 3. Raise out_ready → in_ready returns to 1 the cycle after column 7 of block 1 is accepted.
4. Signed extremes: coefficients -32768 and 32767 in a checkerboard → bit-exact transposed output.
5. Early in_sob at row 3 → sob_err pulses once; the new block (8 rows from that point) is output correctly; the abandoned rows never appear.
6. rst asserted after a full block plus 4 rows → out_valid=0, out_data=0, in_ready=1 next cycle; a fresh block after reset is output correctly.
